issue_queue: RTL

// - Parametrised circular instruction queue between fetch and the dual/N-wide decode stage.
// - Accepts up to ENQ_WIDTH fetched instructions per cycle and presents the oldest DEQ_WIDTH to decode.
// - Retires 0..DEQ_WIDTH head entries per cycle, per decode's single/dual issue decision.
// - Branch flush can preserve the delay-slot instruction, including when it has not been fetched yet.

---
 rtl/issue_queue_pkg.sv | 16 +
 rtl/issue_queue_if.sv | 38 +++
 rtl/iq_popcount.sv | 20 ++
 rtl/issue_queue.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue: entry field layout and FSM encoding.
package issue_queue_pkg;

  localparam int SIZE_OF_CORR_PACK = 88;

  // Entry layout is {corr, pc, inst}, with inst in the lowest bits.
  localparam int INST_LSB = 0;
  localparam int PC_LSB   = 32;
  localparam int CORR_LSB = 64;

  typedef enum logic {
    IQ_NORMAL  = 1'b0,
    IQ_WAIT_DS = 1'b1
  } iq_state_e;

endpackage

// File: rtl/issue_queue_if.sv
// Fetch/decode-facing bundle of the issue queue; master = fetch+decode side, slave = queue.
interface issue_queue_if
  import issue_queue_pkg::*;
#(
  parameter int ENQ_WIDTH = 2,
  parameter int DEQ_WIDTH = 2,
  parameter int CORR_W    = SIZE_OF_CORR_PACK
);
  localparam int IW = $clog2(DEQ_WIDTH + 1);

  // Enqueue is taken on any cycle where enq_ready=1 and enq_valid!=0; issue_cnt
  // entries are consumed from the head unless stall is high.
  logic [ENQ_WIDTH-1:0]        enq_valid;
  logic [32*ENQ_WIDTH-1:0]     enq_inst;
  logic [32*ENQ_WIDTH-1:0]     enq_pc;
  logic [CORR_W*ENQ_WIDTH-1:0] enq_corr;
  logic                        enq_ready;
  logic [DEQ_WIDTH-1:0]        deq_valid;
  logic [32*DEQ_WIDTH-1:0]     deq_inst;
  logic [32*DEQ_WIDTH-1:0]     deq_pc;
  logic [CORR_W*DEQ_WIDTH-1:0] deq_corr;
  logic [IW-1:0]               issue_cnt;
  logic                        stall;
  logic                        flush;
  logic                        flush_keep_ds;
  logic                        ds_pending;

  modport master (
    output enq_valid, enq_inst, enq_pc, enq_corr, issue_cnt, stall, flush, flush_keep_ds,
    input  enq_ready, deq_valid, deq_inst, deq_pc, deq_corr, ds_pending
  );

  modport slave (
    input  enq_valid, enq_inst, enq_pc, enq_corr, issue_cnt, stall, flush, flush_keep_ds,
    output enq_ready, deq_valid, deq_inst, deq_pc, deq_corr, ds_pending
  );

endinterface

// File: rtl/iq_popcount.sv
// Popcount of a per-slot valid vector plus a check that the set bits are contiguous from bit 0.
module iq_popcount #(
  parameter int W = 2
) (
  input  logic [W-1:0]               valid,
  output logic [$clog2(W+1)-1:0]     cnt,
  output logic                       contig
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + {{($clog2(W+1)-1){1'b0}}, valid[i]};
    end
  end

  // A vector of the form 0..01..1 has no overlap with itself plus one.
  assign contig = ((valid & (valid + W'(1))) == '0);

endmodule

// File: rtl/issue_queue.sv
// Circular instruction queue between fetch and decode with delay-slot-preserving flush.
// Optional ISSUE_QUEUE_PERF_EN adds saturating full/empty/flush performance counters.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ENQ_WIDTH = 2,
  parameter int DEQ_WIDTH = 2,
  parameter int CORR_W    = SIZE_OF_CORR_PACK
) (
  input  logic             clk,
  input  logic             rst,
  issue_queue_if.slave     bus
`ifdef ISSUE_QUEUE_PERF_EN
  ,
  output logic [31:0]      perf_full_cycles,
  output logic [31:0]      perf_empty_cycles,
  output logic [31:0]      perf_flush_cnt
`endif
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int NW    = $clog2(ENQ_WIDTH + 1);
  localparam int ENT_W = CORR_LSB + CORR_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail, head_n, tail_n, head_adv;
  logic [CW-1:0]    count, count_n, issue_ext, deq_n;
  logic [NW-1:0]    pop_cnt, enq_n;
  logic             enq_contig, enq_fire;
  iq_state_e        state, state_n;

  iq_popcount #(.W(ENQ_WIDTH)) u_pop (
    .valid  (bus.enq_valid),
    .cnt    (pop_cnt),
    .contig (enq_contig)
  );

  assign bus.enq_ready = (CW'(DEPTH) - count) >= CW'(ENQ_WIDTH);
  assign bus.ds_pending = (state == IQ_WAIT_DS);

  assign issue_ext = CW'(bus.issue_cnt);
  assign deq_n     = bus.stall ? '0 : ((issue_ext < count) ? issue_ext : count);
  assign head_adv  = head + PW'(deq_n);

  // While waiting for the delay slot only slot 0 of the next fetch group is kept.
  assign enq_n    = (state == IQ_WAIT_DS) ? NW'(bus.enq_valid[0]) : pop_cnt;
  assign enq_fire = bus.enq_ready && (enq_n != '0);

  for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_deq
    logic [ENT_W-1:0] ent;
    assign ent = mem[head + PW'(i)];
    assign bus.deq_valid[i]          = CW'(i) < count;
    assign bus.deq_inst[32*i +: 32]  = bus.deq_valid[i] ? ent[INST_LSB +: 32] : '0;
    assign bus.deq_pc[32*i +: 32]    = bus.deq_valid[i] ? ent[PC_LSB +: 32] : '0;
    assign bus.deq_corr[CORR_W*i +: CORR_W] =
      bus.deq_valid[i] ? ent[CORR_LSB +: CORR_W] : '0;
  end

  always_ff @(posedge clk) begin
    if (enq_fire && !bus.flush && !rst) begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (i < int'(enq_n)) begin
          mem[tail + PW'(i)] <= {bus.enq_corr[CORR_W*i +: CORR_W],
                                 bus.enq_pc[32*i +: 32],
                                 bus.enq_inst[32*i +: 32]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IQ_NORMAL;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      state <= state_n;
    end
  end

  always_comb begin
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    state_n = state;
    if (bus.flush) begin
      if (!bus.flush_keep_ds) begin
        tail_n  = head;
        count_n = '0;
        state_n = IQ_NORMAL;
      end else if (count > deq_n) begin
        // The entry just past this cycle's issue group is the delay slot.
        head_n  = head_adv;
        tail_n  = head_adv + PW'(1);
        count_n = CW'(1);
        state_n = IQ_NORMAL;
      end else begin
        head_n  = head_adv;
        tail_n  = head_adv;
        count_n = '0;
        state_n = IQ_WAIT_DS;
      end
    end else begin
      head_n  = head_adv;
      count_n = count + (enq_fire ? CW'(enq_n) : '0) - deq_n;
      if (enq_fire) begin
        tail_n = tail + PW'(enq_n);
        if (state == IQ_WAIT_DS) state_n = IQ_NORMAL;
      end
    end
  end

`ifdef ISSUE_QUEUE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cycles  <= '0;
      perf_empty_cycles <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (count == CW'(DEPTH) && perf_full_cycles != '1)
        perf_full_cycles <= perf_full_cycles + 32'd1;
      if (count == '0 && !bus.stall && perf_empty_cycles != '1)
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
      if (bus.flush && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

  a_issue_le_count: assert property (@(posedge clk) disable iff (rst)
    (!bus.stall && count != '0) |-> (issue_ext <= count));

  a_enq_contig: assert property (@(posedge clk) disable iff (rst) enq_contig);

endmodule
